// File: rtl/ex_flow_ctrl_pkg.sv
// Shared encodings, latencies and state type for the E-stage mul/div flow control.
package ex_flow_ctrl_pkg;

    localparam logic [1:0] MDOP_MULT  = 2'b00;
    localparam logic [1:0] MDOP_MULTU = 2'b01;
    localparam logic [1:0] MDOP_DIV   = 2'b10;
    localparam logic [1:0] MDOP_DIVU  = 2'b11;

    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    function automatic logic [3:0] md_latency(input logic [1:0] mdop);
        logic [3:0] lat;
        case (mdop)
            MDOP_MULT, MDOP_MULTU: lat = MULT_LAT;
            MDOP_DIV, MDOP_DIVU:   lat = DIV_LAT;
            default:               lat = MULT_LAT;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/md_timer.sv
// Mul/div busy timer: loads a latency on launch, counts down, flags the last busy cycle.
module md_timer
    import ex_flow_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] lat,
    output logic       busy,
    output logic       done,
    output logic [3:0] cnt
);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    assign busy = (state_q == BUSY);
    assign done = busy && (cnt_q == 4'd1);
    assign cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (load) begin
            // A launch in the done cycle reloads without passing through IDLE.
            state_d = BUSY;
            cnt_d   = lat;
        end else if (state_q == BUSY) begin
            if (cnt_q <= 4'd1) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_flow_ctrl.sv
// E-stage handshake with mul/div launch control and HI/LO hazard stalling.
module ex_flow_ctrl
    import ex_flow_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       respon,
    input  logic       E_valid,
    input  logic       startE,
    input  logic       HIReadE,
    input  logic       HIWriteE,
    input  logic [1:0] MDopE,
    input  logic       M_allowin,
    output logic       E_allowin,
    output logic       E_to_M_valid,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_done,
    output logic [3:0] md_cnt
);

    logic launched_q, launched_d;
    logic launch;
    logic stall;
    logic E_ready_go;

    assign launch = E_valid && startE && !respon && !launched_q && (!md_busy || md_done);
    assign md_start = launch;

    // Once this E instruction has launched, the busy unit is its own work, not a hazard.
    assign stall = E_valid && md_busy && !md_done && !launched_q
                   && (startE || HIReadE || HIWriteE);

    assign E_ready_go   = !stall;
    assign E_allowin    = !E_valid || (E_ready_go && M_allowin);
    assign E_to_M_valid = E_valid && E_ready_go && !respon;

    // Flag lives while the launching instruction remains in E, preventing a relaunch.
    assign launched_d = (E_allowin || respon) ? 1'b0 : (launched_q || launch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            launched_q <= 1'b0;
        end else begin
            launched_q <= launched_d;
        end
    end

    md_timer u_md_timer (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .lat   (md_latency(MDopE)),
        .busy  (md_busy),
        .done  (md_done),
        .cnt   (md_cnt)
    );

endmodule

// File: tb/tb_ex_flow_ctrl.sv
// Directed, table-driven bench for ex_flow_ctrl plus hand-written multi-cycle sequences.
module tb_ex_flow_ctrl;

    logic       clk;
    logic       reset;
    logic       respon;
    logic       E_valid;
    logic       startE;
    logic       HIReadE;
    logic       HIWriteE;
    logic [1:0] MDopE;
    logic       M_allowin;
    logic       E_allowin;
    logic       E_to_M_valid;
    logic       md_start;
    logic       md_busy;
    logic       md_done;
    logic [3:0] md_cnt;

    int checks;
    int failures;
    int nstart;

    typedef struct {
        string      tag;
        logic       valid;
        logic       start;
        logic       hir;
        logic       hiw;
        logic [1:0] mdop;
        logic       respon;
        logic       mal;
        logic       ea;
        logic       tm;
        logic       st;
        logic       bz;
        logic       dn;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];

    ex_flow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .respon       (respon),
        .E_valid      (E_valid),
        .startE       (startE),
        .HIReadE      (HIReadE),
        .HIWriteE     (HIWriteE),
        .MDopE        (MDopE),
        .M_allowin    (M_allowin),
        .E_allowin    (E_allowin),
        .E_to_M_valid (E_to_M_valid),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_cnt       (md_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string tag, input logic valid, input logic start,
                                input logic hir, input logic hiw, input logic [1:0] mdop,
                                input logic rsp, input logic mal, input logic ea,
                                input logic tm, input logic st, input logic bz,
                                input logic dn, input logic [3:0] cnt);
        vec_t v;
        v.tag = tag; v.valid = valid; v.start = start; v.hir = hir; v.hiw = hiw;
        v.mdop = mdop; v.respon = rsp; v.mal = mal; v.ea = ea; v.tm = tm; v.st = st;
        v.bz = bz; v.dn = dn; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ea, input logic tm, input logic st,
                             input logic bz, input logic dn, input logic [3:0] cnt);
        chk({tag, ".E_allowin"}, {3'b0, E_allowin}, {3'b0, ea});
        chk({tag, ".E_to_M_valid"}, {3'b0, E_to_M_valid}, {3'b0, tm});
        chk({tag, ".md_start"}, {3'b0, md_start}, {3'b0, st});
        chk({tag, ".md_busy"}, {3'b0, md_busy}, {3'b0, bz});
        chk({tag, ".md_done"}, {3'b0, md_done}, {3'b0, dn});
        chk({tag, ".md_cnt"}, md_cnt, cnt);
    endtask

    // Drive one cycle of inputs, check mid-cycle, then advance past the next edge.
    task automatic apply(input vec_t v);
        E_valid = v.valid; startE = v.start; HIReadE = v.hir; HIWriteE = v.hiw;
        MDopE = v.mdop; respon = v.respon; M_allowin = v.mal;
        @(negedge clk);
        if (md_start === 1'b1) nstart++;
        check_all(v.tag, v.ea, v.tm, v.st, v.bz, v.dn, v.cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag, input logic [3:0] cnt);
        apply(mk(tag, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, cnt != 0, cnt == 1, cnt));
    endtask

    initial begin
        checks = 0; failures = 0; nstart = 0;
        reset = 1'b0; respon = 0; E_valid = 0; startE = 0; HIReadE = 0; HIWriteE = 0;
        MDopE = 2'b00; M_allowin = 1;

        @(negedge clk);
        check_all("reset", 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: idle handshake patterns, then full operations.
        tbl.push_back(mk("idle_hiread",   1, 0, 1, 0, 2'b00, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk("idle_m_block",  1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("idle_respon",   1, 0, 0, 0, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("invalid_start", 0, 1, 0, 0, 2'b10, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("after_invalid", 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("respon_start",  1, 1, 0, 0, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("after_respon",  0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("mult_launch",   1, 1, 0, 0, 2'b00, 0, 1, 1, 1, 1, 0, 0, 0));
        for (int k = 5; k >= 1; k--)
            tbl.push_back(mk("mult_busy", 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 1, k == 1, k[3:0]));
        tbl.push_back(mk("mult_idle",     0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("multu_launch",  1, 1, 0, 0, 2'b01, 0, 1, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk("multu_hiwrite", 1, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, 1, 0, 5));
        for (int k = 4; k >= 1; k--)
            tbl.push_back(mk("multu_hiw", 1, 0, 0, 1, 2'b00, 0, 1, k == 1, k == 1, 0, 1, k == 1,
                             k[3:0]));
        tbl.push_back(mk("multu_idle",    0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("div_launch",    1, 1, 0, 0, 2'b10, 0, 1, 1, 1, 1, 0, 0, 0));
        for (int k = 10; k >= 2; k--)
            tbl.push_back(mk("mfhi_stall", 1, 0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 1, 0, k[3:0]));
        tbl.push_back(mk("mfhi_pass",     1, 0, 1, 0, 2'b00, 0, 1, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk("div_idle",      0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Start held in E by M backpressure launches exactly once.
        nstart = 0;
        apply(mk("hold_c0", 1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
        apply(mk("hold_c1", 1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 5));
        apply(mk("hold_c2", 1, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 4));
        apply(mk("hold_c3", 1, 1, 0, 0, 2'b00, 0, 1, 1, 1, 0, 1, 0, 3));
        idle_cycle("hold_c4", 2);
        idle_cycle("hold_c5", 1);
        idle_cycle("hold_c6", 0);
        chk("hold_start_count", nstart[3:0], 4'd1);

        // divu issued during mult's done cycle launches back-to-back.
        apply(mk("b2b_mult", 1, 1, 0, 0, 2'b00, 0, 1, 1, 1, 1, 0, 0, 0));
        for (int k = 5; k >= 2; k--) idle_cycle("b2b_mult_busy", k[3:0]);
        apply(mk("b2b_divu", 1, 1, 0, 0, 2'b11, 0, 1, 1, 1, 1, 1, 1, 1));
        for (int k = 10; k >= 0; k--) idle_cycle("b2b_divu_busy", k[3:0]);

        // respon while busy does not abort the running divide.
        apply(mk("rsp_div", 1, 1, 0, 0, 2'b10, 0, 1, 1, 1, 1, 0, 0, 0));
        for (int k = 10; k >= 8; k--) idle_cycle("rsp_busy", k[3:0]);
        apply(mk("rsp_at7", 1, 0, 0, 0, 2'b00, 1, 1, 1, 0, 0, 1, 0, 7));
        for (int k = 6; k >= 0; k--) idle_cycle("rsp_cont", k[3:0]);

        // Asynchronous reset mid-operation at md_cnt=3.
        apply(mk("rst_div", 1, 1, 0, 0, 2'b10, 0, 1, 1, 1, 1, 0, 0, 0));
        for (int k = 10; k >= 4; k--) idle_cycle("rst_busy", k[3:0]);
        E_valid = 0; startE = 0; respon = 0; M_allowin = 1;
        @(negedge clk);
        check_all("rst_pre", 1, 0, 0, 1, 0, 3);
        #1 reset = 1'b0;
        #1 check_all("rst_async", 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 check_all("rst_hold", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle("rst_after", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
